// File: rtl/dp_unit_vec_if.sv
// dp_unit_vec_if: operand beat and result bus of the sparse dot-product engine
interface dp_unit_vec_if #(
    parameter int DW_DATA = 8,
    parameter int N_LANE  = 4,
    parameter int DW_ACC  = 24,
    parameter int DW_CNT  = 16
);
    logic                      enable;
    logic                      in_beat;
    logic                      in_last;
    logic [N_LANE*DW_DATA-1:0] in_a;
    logic [N_LANE*DW_DATA-1:0] in_b;
    logic [N_LANE-1:0]         in_valid_a;
    logic [N_LANE-1:0]         in_valid_b;
    logic signed [DW_ACC-1:0]  out;
    logic [DW_CNT-1:0]         out_nnz;
    logic                      out_valid;
    logic                      out_sat;

    modport master (
        output enable, in_beat, in_last, in_a, in_b, in_valid_a, in_valid_b,
        input  out, out_nnz, out_valid, out_sat
    );

    modport slave (
        input  enable, in_beat, in_last, in_a, in_b, in_valid_a, in_valid_b,
        output out, out_nnz, out_valid, out_sat
    );
endinterface

// File: rtl/dp_unit_vec.sv
// dp_unit_vec: pipelined sparse dot product with effective-MAC count; DP_VEC_SAT_EN selects clamping accumulation
module dp_unit_vec #(
    parameter int DW_DATA = 8,
    parameter int N_LANE  = 4,
    parameter int DW_ACC  = 24,
    parameter int DW_CNT  = 16
) (
    input logic         clk,
    input logic         reset,
    dp_unit_vec_if.slave bus
);
    localparam int PW = 2 * DW_DATA;
    localparam int LW = $clog2(N_LANE);
    localparam int SW = PW + LW;
    localparam int CW = LW + 1;

    typedef enum logic {IDLE, ACCUM} state_t;

    logic [N_LANE-1:0]         eff;
    logic signed [DW_DATA-1:0] la [N_LANE];
    logic signed [DW_DATA-1:0] lb [N_LANE];
    logic signed [PW-1:0]      prod [N_LANE];
    logic signed [PW-1:0]      p1 [N_LANE];
    logic [CW-1:0]             pc, c1, c2;
    logic                      b1, l1, b2, l2;
    logic signed [SW-1:0]      sum, s2;
    state_t                    state, state_next;
    logic                      step;
    logic signed [DW_ACC-1:0]  acc, acc_base, acc_next, out_q;
    logic [DW_CNT-1:0]         cnt, cnt_next, nnz_q;
    logic                      valid_q;
`ifdef DP_VEC_SAT_EN
    localparam int AW = DW_ACC + 1;
    localparam logic signed [DW_ACC-1:0] ACC_MAX = {1'b0, {(DW_ACC-1){1'b1}}};
    localparam logic signed [DW_ACC-1:0] ACC_MIN = {1'b1, {(DW_ACC-1){1'b0}}};
    logic signed [AW-1:0] wide;
    logic                 clamp, sat, sat_next, sat_q;
`endif

    assign eff  = {N_LANE{bus.in_beat}} & bus.in_valid_a & bus.in_valid_b;
    assign step = bus.enable && b2;

    // Lane products with pruned/non-beat lanes forced to zero, plus the effective-lane popcount
    always_comb begin
        pc = '0;
        for (int i = 0; i < N_LANE; i++) begin
            la[i]   = bus.in_a[i*DW_DATA +: DW_DATA];
            lb[i]   = bus.in_b[i*DW_DATA +: DW_DATA];
            prod[i] = eff[i] ? PW'(la[i]) * PW'(lb[i]) : '0;
            pc      = pc + CW'(eff[i]);
        end
    end

    // Adder tree over the registered products, widened so no lane sum can overflow
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_LANE; i++) sum = sum + SW'(p1[i]);
    end

    // S1/S2 pipeline; non-beat cycles travel as bubbles with beat = 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1 <= '{default: '0};
            c1 <= '0;
            b1 <= 1'b0;
            l1 <= 1'b0;
            s2 <= '0;
            c2 <= '0;
            b2 <= 1'b0;
            l2 <= 1'b0;
        end else if (bus.enable) begin
            p1 <= prod;
            c1 <= pc;
            b1 <= bus.in_beat;
            l1 <= bus.in_beat & bus.in_last;
            s2 <= sum;
            c2 <= c1;
            b2 <= b1;
            l2 <= l1;
        end
    end

    // Accumulator state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A last beat closes the dot product; any other beat keeps accumulating
    always_comb state_next = step ? (l2 ? IDLE : ACCUM) : state;

    // Accumulate step: IDLE starts fresh from this beat, ACCUM adds onto the running totals
    always_comb begin
        acc_base = (state == IDLE) ? '0 : acc;
        cnt_next = ((state == IDLE) ? '0 : cnt) + DW_CNT'(c2);
`ifdef DP_VEC_SAT_EN
        wide     = AW'(acc_base) + AW'(s2);
        clamp    = wide[AW-1] != wide[AW-2];
        acc_next = clamp ? (wide[AW-1] ? ACC_MIN : ACC_MAX) : wide[DW_ACC-1:0];
        sat_next = ((state == IDLE) ? 1'b0 : sat) | clamp;
`else
        acc_next = acc_base + DW_ACC'(s2);
`endif
    end

    // Running totals and result registers; the strobe is never held across a stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            cnt     <= '0;
            out_q   <= '0;
            nnz_q   <= '0;
            valid_q <= 1'b0;
`ifdef DP_VEC_SAT_EN
            sat     <= 1'b0;
            sat_q   <= 1'b0;
`endif
        end else begin
            valid_q <= step && l2;
            if (step) begin
                acc <= l2 ? '0 : acc_next;
                cnt <= l2 ? '0 : cnt_next;
`ifdef DP_VEC_SAT_EN
                sat <= l2 ? 1'b0 : sat_next;
                if (l2) sat_q <= sat_next;
`endif
                if (l2) begin
                    out_q <= acc_next;
                    nnz_q <= cnt_next;
                end
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_nnz   = nnz_q;
    assign bus.out_valid = valid_q;
`ifdef DP_VEC_SAT_EN
    assign bus.out_sat   = sat_q;
`else
    assign bus.out_sat   = 1'b0;
`endif
endmodule

// File: tb/tb_dp_unit_vec.sv
// tb_dp_unit_vec: table vectors, directed corner sequences and random beats against a scoreboard model
module tb_dp_unit_vec;
    localparam logic [31:0] A1   = 32'h02010102;
    localparam logic [31:0] B1   = 32'h020101FE;
    localparam logic [31:0] A127 = 32'h7F7F7F7F;
    localparam logic [31:0] AM   = 32'h80808080;
    localparam logic [3:0]  F    = 4'hF;
    localparam longint ACC_MAX = 64'sd8388607;
    localparam longint ACC_MIN = -64'sd8388608;
`ifdef DP_VEC_SAT_EN
    localparam longint OVF_OUT = 8388607;
    localparam bit     OVF_SAT = 1'b1;
`else
    localparam longint OVF_OUT = -8388608;
    localparam bit     OVF_SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;
    int   n;

    always #5 clk = ~clk;

    dp_unit_vec_if bus();
    dp_unit_vec dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        longint val;
        longint nnz;
        bit     sat;
        int     at_edge;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  va;
        logic [3:0]  vb;
        longint      out;
        longint      nnz;
    } vec_t;

    res_t   exp_q[$];
    res_t   r;
    vec_t   vecs[8];
    longint m_acc = 0;
    longint m_s;
    longint m_cnt = 0;
    bit     m_sat = 0;
    logic signed [23:0] m_wrap;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: per-beat dot product from the lane rules, clamped or wrapped per accumulate step
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_acc = 0;
            m_cnt = 0;
            m_sat = 0;
            exp_q.delete();
        end else if (bus.enable) begin
            en_cnt++;
            if (bus.in_beat) begin
                m_s = 0;
                for (int i = 0; i < 4; i++)
                    if (bus.in_valid_a[i] && bus.in_valid_b[i]) begin
                        m_s += longint'($signed(bus.in_a[i*8 +: 8])) * longint'($signed(bus.in_b[i*8 +: 8]));
                        m_cnt++;
                    end
                m_acc += m_s;
`ifdef DP_VEC_SAT_EN
                if (m_acc > ACC_MAX) begin m_acc = ACC_MAX; m_sat = 1; end
                else if (m_acc < ACC_MIN) begin m_acc = ACC_MIN; m_sat = 1; end
`endif
                if (bus.in_last) begin
                    m_wrap = m_acc[23:0];
                    exp_q.push_back('{longint'(m_wrap), m_cnt % 65536, m_sat, en_cnt + 2});
                    m_acc = 0;
                    m_cnt = 0;
                    m_sat = 0;
                end
            end
        end
    end

    // Scoreboard: every strobe must match the next modelled result, in value and enabled-edge latency
    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got out=%0d nnz=%0d, expected no result", bus.out, bus.out_nnz);
            end else begin
                r = exp_q.pop_front();
                chk("sb_out", longint'(bus.out), r.val);
                chk("sb_nnz", longint'(bus.out_nnz), r.nnz);
                chk("sb_sat", longint'(bus.out_sat), longint'(r.sat));
                chk("sb_latency", en_cnt, r.at_edge);
            end
        end
    end

    task automatic drive(input bit en, input bit bt, input bit lst, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] va, input logic [3:0] vb);
        bus.enable     = en;
        bus.in_beat    = bt;
        bus.in_last    = lst;
        bus.in_a       = a;
        bus.in_b       = b;
        bus.in_valid_a = va;
        bus.in_valid_b = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input string nm, input int bound, input longint eo, input longint en,
                               input bit es, output int cyc);
        cyc = 0;
        bus.enable  = 1'b1;
        bus.in_beat = 1'b0;
        bus.in_last = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.out_valid && cyc < bound);
        if (!bus.out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no out_valid in %0d cycles, expected a result", nm, bound);
        end else begin
            chk({nm, "_out"}, longint'(bus.out), eo);
            chk({nm, "_nnz"}, longint'(bus.out_nnz), en);
            chk({nm, "_sat"}, longint'(bus.out_sat), longint'(es));
        end
    endtask

    initial begin
        vecs[0] = '{A1, B1, F, F, 2, 4};
        vecs[1] = '{A1, B1, 4'b0011, 4'b0101, -4, 1};
        vecs[2] = '{A1, B1, 4'b0000, F, 0, 0};
        vecs[3] = '{A127, A127, F, F, 64516, 4};
        vecs[4] = '{AM, A127, F, F, -65024, 4};
        vecs[5] = '{A1, B1, 4'b1010, F, 5, 2};
        vecs[6] = '{AM, AM, F, F, 65536, 4};
        vecs[7] = '{A127, AM, 4'b1000, 4'b1001, -16256, 1};

        bus.enable = 1'b0;
        bus.in_beat = 1'b0;
        bus.in_last = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_valid_a = '0;
        bus.in_valid_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", longint'(bus.out), 0);
        chk("reset_nnz", longint'(bus.out_nnz), 0);
        chk("reset_valid", longint'(bus.out_valid), 0);
        chk("reset_sat", longint'(bus.out_sat), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1, vecs[i].a, vecs[i].b, vecs[i].va, vecs[i].vb);
            wait_result($sformatf("vec%0d", i), 8, vecs[i].out, vecs[i].nnz, 0, n);
            chk($sformatf("vec%0d_latency", i), n, 3);
        end

        drive(1, 1, 0, A127, A127, F, F);
        drive(1, 1, 0, A127, A127, F, F);
        drive(1, 1, 1, A127, A127, F, F);
        drive(1, 1, 1, A1, B1, F, F);
        wait_result("b2b_first", 4, 193548, 12, 0, n);
        wait_result("b2b_second", 1, 2, 4, 0, n);
        @(negedge clk);
        chk("b2b_strobe_once", longint'(bus.out_valid), 0);
        repeat (3) @(negedge clk);
        chk("hold_out", longint'(bus.out), 2);
        chk("hold_nnz", longint'(bus.out_nnz), 4);

        drive(1, 1, 0, A127, A127, F, F);
        drive(1, 1, 0, A127, A127, F, F);
        drive(0, 1, 1, AM, AM, F, F);
        drive(0, 1, 1, AM, AM, F, F);
        drive(1, 1, 1, A127, A127, F, F);
        drive(0, 1, 0, AM, AM, F, F);
        chk("stall_no_strobe1", longint'(bus.out_valid), 0);
        drive(0, 1, 0, AM, AM, F, F);
        chk("stall_no_strobe2", longint'(bus.out_valid), 0);
        chk("stall_hold_out", longint'(bus.out), 2);
        wait_result("stall", 6, 193548, 12, 0, n);
        @(negedge clk);
        chk("stall_strobe_once", longint'(bus.out_valid), 0);

        for (int k = 0; k < 128; k++) drive(1, 1, k == 127, AM, AM, F, F);
        wait_result("ovf", 6, OVF_OUT, 512, OVF_SAT, n);
        drive(1, 1, 1, A1, B1, F, F);
        wait_result("ovf_sat_clear", 6, 2, 4, 0, n);

        for (int k = 0; k < 400; k++)
            drive(($urandom % 5) != 0, ($urandom % 4) != 0, ($urandom % 4) == 0, $urandom, $urandom,
                  4'($urandom), 4'($urandom));
        drive(1, 1, 1, A127, A127, F, F);
        drive(1, 1, 1, A1, B1, F, F);
        bus.in_beat = 1'b0;
        repeat (6) @(negedge clk);
        chk("rand_drained", exp_q.size(), 0);
        chk("pre_reset_out", longint'(bus.out), 2);

        drive(1, 1, 0, A127, A127, F, F);
        drive(1, 1, 0, A127, A127, F, F);
        reset = 1'b1;
        #1;
        chk("async_reset_out", longint'(bus.out), 0);
        chk("async_reset_nnz", longint'(bus.out_nnz), 0);
        chk("async_reset_valid", longint'(bus.out_valid), 0);
        chk("async_reset_sat", longint'(bus.out_sat), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1, 1, 1, A1, B1, F, F);
        wait_result("post_reset", 6, 2, 4, 0, n);
        repeat (4) @(negedge clk);
        chk("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dp_unit_vec.md
# dp_unit_vec

Parametrised, pipelined sparse dot-product engine for the unstructured-sparsity datapath: the next generation of the scalar `dp_unit`. Each beat, it multiplies N_LANE signed operand pairs and skips any lane whose A or B element is flagged invalid (zero/pruned). It reduces the surviving products with an adder tree and accumulates across beats until a `last` beat. It then emits the dot product and a count of the effective MACs performed, and sits between the sparse operand gather logic and the output tile buffer.

## Interface
- DW_DATA, 8, signed operand width.
- N_LANE, 4, lanes per beat (power of 2, ≥2).
- DW_ACC, 24, accumulator/result width; must be ≥ 2*DW_DATA+$clog2(N_LANE).
- DW_CNT, 16, width of the effective-MAC counter.

- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  pipeline advance; 0 freezes every stage.
- in_beat  in  1  beat qualifier; the lane inputs are ignored when 0.
- in_last  in  1  marks the final beat of a dot product (qualified by in_beat).
- in_a  in  N_LANE*DW_DATA  signed, lane i at [i*DW_DATA +: DW_DATA].
- in_b  in  N_LANE*DW_DATA  signed, same packing.
- in_valid_a  in  N_LANE  per-lane A element present.
- in_valid_b  in  N_LANE  per-lane B element present.
- out  out  DW_ACC  signed dot-product result.
- out_nnz  out  DW_CNT  number of effective lane MACs in the result.
- out_valid  out  1  one-cycle result strobe.
- out_sat  out  1  result was clamped (saturation build only).

## Operation
- Lane i is effective when in_beat & in_valid_a[i] & in_valid_b[i]. Its product is then in_a[i]*in_b[i] (signed, 2*DW_DATA bits); otherwise the product is forced to 0.
- S1 register: masked products, the popcount of effective lanes, beat, last.
- S2 register: adder-tree sum, sign-extended to 2*DW_DATA+$clog2(N_LANE), carrying the popcount, beat, and last.
- S3 accumulator, two states:
  - IDLE: the next S2 beat loads acc = sum and cnt = popcount, then goes to ACCUM.
  - ACCUM: acc += sum and cnt += popcount.
  - A beat with last, in either state, drives out = acc_next, out_nnz = cnt_next, out_valid = 1. It then clears acc/cnt and returns to IDLE.
  - A single-beat dot product (first beat also last) is legal.
- Non-beat cycles (in_beat = 0) flow as bubbles and do not touch acc, cnt, or state.
- out and out_nnz hold their value until the next result. cnt wraps at 2^DW_CNT.
- Reset asserted mid-dot-product discards the partial sum. All outputs and state go to 0 and IDLE, and the in-flight pipeline beats are dropped.

## Timing
- Reset values: out = 0, out_nnz = 0, out_valid = 0, out_sat = 0, state IDLE, all pipeline valids 0.
- Latency: a last beat sampled at edge t with enable = 1 asserts out_valid after edge t+2, visible for exactly one cycle. This is 3 enabled edges, inclusive.
- Throughput: one beat per enabled cycle, with no back-to-back penalty between dot products.
- enable = 0: all S1/S2/S3 registers, acc, cnt, state, out, and out_nnz hold. out_valid is driven 0, so there is never a duplicate strobe. A pending result strobes on the first enabled edge after the stall.
- in_* inputs are sampled only when enable = 1.

## Configuration
- DP_VEC_SAT_EN defined: every accumulate step clamps to [-2^(DW_ACC-1), 2^(DW_ACC-1)-1].
  - A clamp sets a sticky flag for the current dot product.
  - out_sat is presented with out_valid and cleared on the next result.
- DP_VEC_SAT_EN undefined: two's-complement wrap in DW_ACC bits, and out_sat is tied to 0.

## Test plan
All scenarios use the defaults (DW_DATA = 8, N_LANE = 4, DW_ACC = 24).
1. Single beat, a = {2,1,1,2}, b = {-2,1,1,2}, both valids 4'b1111, last = 1 -> out = 2, out_nnz = 4, out_valid pulses 3 enabled edges after input.
2. Masking: same data, valid_a = 4'b0011, valid_b = 4'b0101 -> out = -4, out_nnz = 1. With valid_a = 0 -> out = 0, out_nnz = 0, out_valid still pulses.
3. Three beats, all lanes a = 127, b = 127, last on beat 3, then an immediate single beat from scenario 1:
   - first result out = 193548, out_nnz = 12;
   - next cycle out = 2, out_nnz = 4 (no carry-over).
4. Stall: scenario 3 with enable = 0 for 2 cycles after beat 2 -> the result arrives 2 cycles later, values unchanged, out_valid high for exactly 1 cycle.
5. Overflow: 128 beats of a = -128, b = -128 on all lanes (65536 per beat, total 8388608):
   - with DP_VEC_SAT_EN -> out = 8388607, out_sat = 1;
   - without -> out = -8388608, out_sat = 0;
   - out_nnz = 512 in both builds.
6. Reset pulse after 2 beats of scenario 3 -> all outputs 0 immediately. A following scenario-1 beat yields out = 2, out_nnz = 4.
